// File: rtl/serial_comparator.sv
// serial_comparator: compares two unsigned operands of NDIG 2-bit digits,
// presented MSB-first one digit pair per accepted cycle. The first digit
// pair that differs fixes the result; remaining digits are still consumed.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - begin a new comparison (accepted only in IDLE)
//   in_valid  - a_dig/b_dig hold a valid digit pair this cycle (SCAN only)
//   a_dig     - current digit of operand A
//   b_dig     - current digit of operand B
//   busy      - high while scanning digits
//   out_valid - one-cycle pulse when agb/aeb/alb receive a new result
//   agb/aeb/alb - registered A>B / A==B / A<B, held until the next result
module serial_comparator #(
  parameter int NDIG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] a_dig,
  input  logic [1:0] b_dig,
  output logic       busy,
  output logic       out_valid,
  output logic       agb,
  output logic       aeb,
  output logic       alb
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_e;

  state_e        state_q;
  dec_e          dec_q;
  dec_e          dec_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          out_valid_q;
  logic          agb_q;
  logic          aeb_q;
  logic          alb_q;
  logic          last_dig;

  // Decision after the current digit pair; frozen once it leaves EQ.
  always_comb begin
    dec_d = dec_q;
    if (dec_q == DEC_EQ) begin
      if (a_dig > b_dig) begin
        dec_d = DEC_GT;
      end else if (a_dig < b_dig) begin
        dec_d = DEC_LT;
      end
    end
  end

  assign last_dig = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_q       <= DEC_EQ;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      agb_q       <= 1'b0;
      aeb_q       <= 1'b0;
      alb_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (start) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            dec_q   <= DEC_EQ;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (in_valid) begin
            cnt_q <= cnt_q + CW'(1);
            dec_q <= dec_d;
            // Result is loaded from dec_d so the last digit can still decide.
            if (last_dig) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              agb_q       <= (dec_d == DEC_GT);
              aeb_q       <= (dec_d == DEC_EQ);
              alb_q       <= (dec_d == DEC_LT);
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign agb       = agb_q;
  assign aeb       = aeb_q;
  assign alb       = alb_q;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of 2-bit digits per operand (operand width 2*NDIG, NDIG >= 1).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a new comparison when accepted.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a_dig/b_dig carry a valid digit pair this cycle.
REQ-007 The block SHALL have port a_dig, input, 2 bits: current digit of operand A, MSB-first.
REQ-008 The block SHALL have port b_dig, input, 2 bits: current digit of operand B, MSB-first.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-010 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a final result.
REQ-011 The block SHALL have ports agb, aeb and alb, output, 1 bit each: registered result A>B, A==B, A<B.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL move the FSM to SCAN, clear the digit counter, and set the internal decision to EQ.
REQ-014 In IDLE, in_valid SHALL be ignored.
REQ-015 In SCAN, each edge with in_valid=1 SHALL consume one digit pair and increment the digit counter; edges with in_valid=0 SHALL change nothing.
REQ-016 While the decision is EQ, a consumed pair SHALL set the decision to GT if a_dig>b_dig (unsigned) and to LT if a_dig<b_dig.
REQ-017 Once the decision is GT or LT, it SHALL be frozen; later digits are still consumed and counted.
REQ-018 At the edge consuming digit NDIG, the FSM SHALL enter DONE and load agb/aeb/alb from the final decision (exactly one high).
REQ-019 out_valid SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-020 Latency SHALL be: result visible in the cycle after the edge that consumed the last digit; with continuous in_valid, NDIG+1 cycles from start acceptance to out_valid.
REQ-021 agb/aeb/alb SHALL hold their value after DONE until the next result is loaded; they SHALL NOT change during SCAN.
REQ-022 start SHALL be ignored in SCAN and in DONE; a comparison already in progress is never restarted.
REQ-023 start held high SHALL be accepted on the first IDLE edge after DONE.
REQ-024 The digit counter SHALL be ceil(log2(NDIG+1)) bits wide and SHALL never wrap within a comparison.

Reset
REQ-025 On rst_n=0, asynchronously: FSM=IDLE, counter=0, decision=EQ, busy=0, out_valid=0, agb=0, aeb=0, alb=0.
REQ-026 rst_n=0 during SCAN SHALL abort the comparison with no out_valid pulse; operation resumes only on a new start after rst_n=1.

Verification (NDIG=2, in_valid continuous unless stated)
REQ-027 Scenario 1: start, then digits (11,10) vs (10,11) -> out_valid 3 cycles after start edge, agb=1, aeb=0, alb=0.
REQ-028 Scenario 2: start, then digits (01,10) vs (01,10) -> aeb=1. Also run with A=(00,11), B=(01,00) -> alb=1 (MSB decides).
REQ-029 Scenario 3: digits (10,xx) vs (01,xx), where xx is any later digit value -> agb=1 regardless of the second digit.
REQ-030 Scenario 4: in_valid gaps (1,0,0,1) with A=(10,01), B=(10,10) -> alb=1 one cycle after the second valid edge; busy high throughout the gaps.
REQ-031 Scenario 5: start pulsed mid-SCAN and during DONE -> ignored; result unchanged, single out_valid pulse.
REQ-032 Scenario 6: rst_n low after the first digit -> all outputs 0 immediately; no out_valid; a new start then compares fresh (A=B=(11,11) -> aeb=1).
